// File: rtl/wb_stage.sv
// Write-back stage of the 5-stage MIPS pipeline: commits results to the register
// file and owns CP0 (Status, Cause, EPC, BadVAddr, Count, Compare) plus exception/ERET redirect.
module wb_stage #(
  parameter logic [31:0] EX_ENTRY        = 32'hBFC0_0380,
  parameter int          MS_TO_WS_BUS_WD = 155
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  input  logic [5:0]                 ext_int_in,
  output logic                       ws_handle_ex,
  output logic [31:0]                ws_flush_pc,
  output logic [3:0]                 rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_COUNT    = 8'h48;
  localparam logic [7:0] CP0_COMPARE  = 8'h58;
  localparam logic [7:0] CP0_STATUS   = 8'h60;
  localparam logic [7:0] CP0_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_EPC      = 8'h70;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  logic                       ws_valid_r;
  logic [MS_TO_WS_BUS_WD-1:0] ws_bus_r;
  logic                       ready_go_s;

  logic        bus_ex_s;
  logic [4:0]  bus_exccode_s;
  logic        bus_bd_s;
  logic [31:0] bus_badvaddr_s;
  logic        bus_eret_s;
  logic        bus_mtc0_s;
  logic [7:0]  bus_cp0_addr_s;
  logic [31:0] bus_cp0_wdata_s;
  logic        bus_res_from_cp0_s;
  logic [3:0]  bus_rf_we_s;
  logic [4:0]  bus_dest_s;
  logic [31:0] bus_result_s;
  logic [31:0] bus_pc_s;

  // CP0 architectural state; only writable / hardware-updated fields are stored
  logic [7:0]  status_im_r;
  logic        status_exl_r;
  logic        status_ie_r;
  logic        cause_bd_r;
  logic        cause_ti_r;
  logic [1:0]  cause_ip_sw_r;
  logic [5:0]  ext_int_r;
  logic [4:0]  cause_exccode_r;
  logic [31:0] epc_r;
  logic [31:0] badvaddr_r;
  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        tick_r;

  logic [31:0] status_s;
  logic [31:0] cause_s;
  logic [7:0]  cause_ip_s;
  logic [31:0] cp0_rdata_s;

  logic        int_pend_s;
  logic        ex_take_s;
  logic        eret_take_s;
  logic [4:0]  exc_code_s;
  logic        mtc0_we_s;
  logic        wr_status_s;
  logic        wr_cause_s;
  logic        wr_epc_s;
  logic        wr_count_s;
  logic        wr_compare_s;

  assign bus_ex_s           = ws_bus_r[154];
  assign bus_exccode_s      = ws_bus_r[153:149];
  assign bus_bd_s           = ws_bus_r[148];
  assign bus_badvaddr_s     = ws_bus_r[147:116];
  assign bus_eret_s         = ws_bus_r[115];
  assign bus_mtc0_s         = ws_bus_r[114];
  assign bus_cp0_addr_s     = ws_bus_r[113:106];
  assign bus_cp0_wdata_s    = ws_bus_r[105:74];
  assign bus_res_from_cp0_s = ws_bus_r[73];
  assign bus_rf_we_s        = ws_bus_r[72:69];
  assign bus_dest_s         = ws_bus_r[68:64];
  assign bus_result_s       = ws_bus_r[63:32];
  assign bus_pc_s           = ws_bus_r[31:0];

  assign ready_go_s = 1'b1;
  assign ws_allowin = !ws_valid_r || ready_go_s;

  // Pipeline register; a flush drops whatever the memory stage offers this cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws_valid_r <= 1'b0;
      ws_bus_r   <= '0;
    end else begin
      if (ws_handle_ex) begin
        ws_valid_r <= 1'b0;
      end else if (ws_allowin) begin
        ws_valid_r <= ms_to_ws_valid;
      end else begin
        ws_valid_r <= ws_valid_r;
      end
      if (ms_to_ws_valid && ws_allowin) begin
        ws_bus_r <= ms_to_ws_bus;
      end else begin
        ws_bus_r <= ws_bus_r;
      end
    end
  end

  // IP7 is shared between external line 5 and the timer
  assign cause_ip_s = {ext_int_r[5] | cause_ti_r, ext_int_r[4:0], cause_ip_sw_r};
  assign status_s   = {9'd0, 1'b1, 6'd0, status_im_r, 6'd0, status_exl_r, status_ie_r};
  assign cause_s    = {cause_bd_r, cause_ti_r, 14'd0, cause_ip_s, 1'b0, cause_exccode_r, 2'd0};

  assign int_pend_s  = status_ie_r && !status_exl_r && (|(cause_ip_s & status_im_r));
  assign ex_take_s   = ws_valid_r && (int_pend_s || bus_ex_s);
  assign eret_take_s = ws_valid_r && bus_eret_s && !ex_take_s;
  assign exc_code_s  = int_pend_s ? EXC_INT : bus_exccode_s;

  assign mtc0_we_s    = ws_valid_r && bus_mtc0_s && !ex_take_s;
  assign wr_status_s  = mtc0_we_s && (bus_cp0_addr_s == CP0_STATUS);
  assign wr_cause_s   = mtc0_we_s && (bus_cp0_addr_s == CP0_CAUSE);
  assign wr_epc_s     = mtc0_we_s && (bus_cp0_addr_s == CP0_EPC);
  assign wr_count_s   = mtc0_we_s && (bus_cp0_addr_s == CP0_COUNT);
  assign wr_compare_s = mtc0_we_s && (bus_cp0_addr_s == CP0_COMPARE);

  // CP0 read mux for mfc0
  always_comb begin
    cp0_rdata_s = 32'd0;
    case (bus_cp0_addr_s)
      CP0_BADVADDR: cp0_rdata_s = badvaddr_r;
      CP0_COUNT:    cp0_rdata_s = count_r;
      CP0_COMPARE:  cp0_rdata_s = compare_r;
      CP0_STATUS:   cp0_rdata_s = status_s;
      CP0_CAUSE:    cp0_rdata_s = cause_s;
      CP0_EPC:      cp0_rdata_s = epc_r;
      default:      cp0_rdata_s = 32'd0;
    endcase
  end

  // Status: exception entry sets EXL, ERET clears it, mtc0 has lowest priority
  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_im_r  <= 8'd0;
      status_exl_r <= 1'b0;
      status_ie_r  <= 1'b0;
    end else if (ex_take_s) begin
      status_exl_r <= 1'b1;
    end else if (eret_take_s) begin
      status_exl_r <= 1'b0;
    end else if (wr_status_s) begin
      status_im_r  <= bus_cp0_wdata_s[15:8];
      status_exl_r <= bus_cp0_wdata_s[1];
      status_ie_r  <= bus_cp0_wdata_s[0];
    end else begin
      status_im_r  <= status_im_r;
      status_exl_r <= status_exl_r;
      status_ie_r  <= status_ie_r;
    end
  end

  // Cause: ExcCode/BD on exception entry, software IP via mtc0, hardware lines sampled every cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cause_bd_r      <= 1'b0;
      cause_exccode_r <= 5'd0;
      cause_ip_sw_r   <= 2'd0;
      ext_int_r       <= 6'd0;
    end else begin
      ext_int_r <= ext_int_in;
      if (ex_take_s) begin
        cause_exccode_r <= exc_code_s;
        cause_bd_r      <= status_exl_r ? cause_bd_r : bus_bd_s;
        cause_ip_sw_r   <= cause_ip_sw_r;
      end else if (wr_cause_s) begin
        cause_exccode_r <= cause_exccode_r;
        cause_bd_r      <= cause_bd_r;
        cause_ip_sw_r   <= bus_cp0_wdata_s[9:8];
      end else begin
        cause_exccode_r <= cause_exccode_r;
        cause_bd_r      <= cause_bd_r;
        cause_ip_sw_r   <= cause_ip_sw_r;
      end
    end
  end

  // EPC: captured only on first-level exception entry (nested entries keep the original)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      epc_r <= 32'd0;
    end else if (ex_take_s && !status_exl_r) begin
      epc_r <= bus_bd_s ? (bus_pc_s - 32'd4) : bus_pc_s;
    end else if (wr_epc_s && !ex_take_s) begin
      epc_r <= bus_cp0_wdata_s;
    end else begin
      epc_r <= epc_r;
    end
  end

  // BadVAddr is hardware-written only, by address-error exceptions
  always_ff @(posedge clk) begin
    if (!resetn) begin
      badvaddr_r <= 32'd0;
    end else if (ex_take_s && ((exc_code_s == EXC_ADEL) || (exc_code_s == EXC_ADES))) begin
      badvaddr_r <= bus_badvaddr_s;
    end else begin
      badvaddr_r <= badvaddr_r;
    end
  end

  // Count advances at half the clock rate; an mtc0 write replaces that cycle's increment
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_r  <= 1'b0;
      count_r <= 32'd0;
    end else begin
      tick_r <= ~tick_r;
      if (wr_count_s) begin
        count_r <= bus_cp0_wdata_s;
      end else if (tick_r) begin
        count_r <= count_r + 32'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Compare and sticky timer interrupt; writing Compare acknowledges TI
  always_ff @(posedge clk) begin
    if (!resetn) begin
      compare_r  <= 32'd0;
      cause_ti_r <= 1'b0;
    end else if (wr_compare_s) begin
      compare_r  <= bus_cp0_wdata_s;
      cause_ti_r <= 1'b0;
    end else if (count_r == compare_r) begin
      compare_r  <= compare_r;
      cause_ti_r <= 1'b1;
    end else begin
      compare_r  <= compare_r;
      cause_ti_r <= cause_ti_r;
    end
  end

  assign ws_handle_ex = ex_take_s || (ws_valid_r && bus_eret_s);
  assign ws_flush_pc  = ex_take_s ? EX_ENTRY : epc_r;

  assign rf_we    = (ws_valid_r && !ex_take_s) ? bus_rf_we_s : 4'd0;
  assign rf_waddr = bus_dest_s;
  assign rf_wdata = bus_res_from_cp0_s ? cp0_rdata_s : bus_result_s;

  assign debug_wb_pc       = bus_pc_s;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: commits, exceptions, ERET, CP0 access and the Count/Compare timer.
module tb_wb_stage;

  logic         clk;
  logic         resetn;
  logic         ms_to_ws_valid;
  logic [154:0] ms_to_ws_bus;
  logic         ws_allowin;
  logic [5:0]   ext_int_in;
  logic         ws_handle_ex;
  logic [31:0]  ws_flush_pc;
  logic [3:0]   rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  int n_checks;
  int n_fail;

  wb_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_allowin        (ws_allowin),
    .ext_int_in        (ext_int_in),
    .ws_handle_ex      (ws_handle_ex),
    .ws_flush_pc       (ws_flush_pc),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [154:0] mk_bus(
    input logic ex, input logic [4:0] code, input logic bd, input logic [31:0] bva,
    input logic eret, input logic mtc0, input logic [7:0] addr, input logic [31:0] wd,
    input logic rc, input logic [3:0] we, input logic [4:0] dest, input logic [31:0] res,
    input logic [31:0] pc);
    return {ex, code, bd, bva, eret, mtc0, addr, wd, rc, we, dest, res, pc};
  endfunction

  function automatic logic [154:0] alu_op(input logic [3:0] we, input logic [4:0] dest,
                                          input logic [31:0] res, input logic [31:0] pc);
    return mk_bus(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, we, dest, res, pc);
  endfunction

  function automatic logic [154:0] mfc0_op(input logic [7:0] addr, input logic [3:0] we);
    return mk_bus(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, addr, 32'd0, 1'b1, we, 5'd2,
                  32'hDEAD_BEEF, 32'hBFC0_1000);
  endfunction

  function automatic logic [154:0] mtc0_op(input logic [7:0] addr, input logic [31:0] wd);
    return mk_bus(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b1, addr, wd, 1'b0, 4'd0, 5'd0,
                  32'd0, 32'hBFC0_2000);
  endfunction

  // Present one instruction; returns at the negedge while it sits in WB
  task automatic issue(input logic [154:0] b);
    @(negedge clk);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = b;
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
  endtask

  task automatic read_cp0(input logic [7:0] addr, output logic [31:0] val);
    issue(mfc0_op(addr, 4'hF));
    val = rf_wdata;
  endtask

  logic [31:0] v;

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    resetn         = 1'b0;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    ext_int_in     = 6'd0;
    repeat (2) @(negedge clk);
    check_eq("reset_rf_we", {28'd0, rf_we}, 32'd0);
    check_eq("reset_handle_ex", {31'd0, ws_handle_ex}, 32'd0);
    check_eq("reset_wb_pc", debug_wb_pc, 32'd0);
    check_eq("reset_flush_pc", ws_flush_pc, 32'd0);
    resetn = 1'b1;

    // mfc0 Status after reset with a partial byte-enable
    issue(mfc0_op(8'h60, 4'b1100));
    check_eq("mfc0_status_rst", rf_wdata, 32'h0040_0000);
    check_eq("mfc0_partial_we", {28'd0, rf_we}, 32'h0000_000C);

    // Plain ALU commit
    issue(alu_op(4'hF, 5'd5, 32'h0000_1234, 32'hBFC0_0010));
    check_eq("alu_we", {28'd0, rf_we}, 32'h0000_000F);
    check_eq("alu_waddr", {27'd0, rf_waddr}, 32'd5);
    check_eq("alu_wdata", rf_wdata, 32'h0000_1234);
    check_eq("alu_handle_ex", {31'd0, ws_handle_ex}, 32'd0);
    check_eq("alu_dbg_pc", debug_wb_pc, 32'hBFC0_0010);
    check_eq("alu_dbg_wdata", debug_wb_rf_wdata, 32'h0000_1234);
    check_eq("alu_dbg_wnum", {27'd0, debug_wb_rf_wnum}, 32'd5);
    check_eq("alu_dbg_wen", {28'd0, debug_wb_rf_wen}, 32'h0000_000F);

    // Syscall in a delay slot, with a younger instruction offered in the same cycle
    issue(mk_bus(1'b1, 5'd8, 1'b1, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 4'hF, 5'd7,
                 32'h1111_1111, 32'hBFC0_0104));
    check_eq("sys_handle_ex", {31'd0, ws_handle_ex}, 32'd1);
    check_eq("sys_flush_pc", ws_flush_pc, 32'hBFC0_0380);
    check_eq("sys_rf_we", {28'd0, rf_we}, 32'd0);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = alu_op(4'hF, 5'd9, 32'h2222_2222, 32'hBFC0_0108);
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
    check_eq("sys_drop_we", {28'd0, rf_we}, 32'd0);
    check_eq("sys_drop_ex", {31'd0, ws_handle_ex}, 32'd0);
    read_cp0(8'h70, v);
    check_eq("sys_epc", v, 32'hBFC0_0100);
    read_cp0(8'h68, v);
    check_eq("sys_cause_bd_code", v & 32'h8000_007C, 32'h8000_0020);
    read_cp0(8'h60, v);
    check_eq("sys_status_exl", v, 32'h0040_0002);

    // AdEL while EXL=1: BadVAddr captured, EPC and BD untouched
    issue(mk_bus(1'b1, 5'd4, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 4'hF,
                 5'd3, 32'd0, 32'hBFC0_0300));
    check_eq("adel_handle_ex", {31'd0, ws_handle_ex}, 32'd1);
    read_cp0(8'h40, v);
    check_eq("adel_badvaddr", v, 32'h0000_0003);
    read_cp0(8'h70, v);
    check_eq("adel_epc_kept", v, 32'hBFC0_0100);
    read_cp0(8'h68, v);
    check_eq("adel_cause", v & 32'h8000_007C, 32'h8000_0010);

    // ERET back to a software-written EPC
    issue(mtc0_op(8'h70, 32'hBFC0_0200));
    issue(mk_bus(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 4'd0, 5'd0,
                 32'd0, 32'hBFC0_0400));
    check_eq("eret_handle_ex", {31'd0, ws_handle_ex}, 32'd1);
    check_eq("eret_flush_pc", ws_flush_pc, 32'hBFC0_0200);
    read_cp0(8'h60, v);
    check_eq("eret_status", v, 32'h0040_0000);

    // Timer: Count=0, Compare=10, TI appears about 20 cycles later
    issue(mtc0_op(8'h48, 32'd0));
    issue(mtc0_op(8'h58, 32'd10));
    read_cp0(8'h68, v);
    check_eq("timer_ti_early", v & 32'h4000_8000, 32'd0);
    read_cp0(8'h58, v);
    check_eq("timer_compare", v, 32'd10);
    repeat (30) @(negedge clk);
    read_cp0(8'h68, v);
    check_eq("timer_ti_set", v & 32'h4000_8000, 32'h4000_8000);
    issue(mtc0_op(8'h60, 32'h0000_8001));
    check_eq("timer_mtc0_no_ex", {31'd0, ws_handle_ex}, 32'd0);
    issue(alu_op(4'hF, 5'd4, 32'h3333_3333, 32'hBFC0_0500));
    check_eq("timer_int_ex", {31'd0, ws_handle_ex}, 32'd1);
    check_eq("timer_int_pc", ws_flush_pc, 32'hBFC0_0380);
    check_eq("timer_int_we", {28'd0, rf_we}, 32'd0);
    read_cp0(8'h68, v);
    check_eq("timer_int_code", v & 32'h0000_007C, 32'd0);
    read_cp0(8'h70, v);
    check_eq("timer_int_epc", v, 32'hBFC0_0500);
    issue(mtc0_op(8'h58, 32'd10));
    read_cp0(8'h68, v);
    check_eq("timer_ti_clear", v & 32'h4000_8000, 32'd0);

    // Reset mid-operation discards the WB instruction and restores CP0
    @(negedge clk);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = alu_op(4'hF, 5'd6, 32'h4444_4444, 32'hBFC0_0600);
    resetn         = 1'b0;
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
    resetn         = 1'b1;
    check_eq("rst_mid_we", {28'd0, rf_we}, 32'd0);
    read_cp0(8'h60, v);
    check_eq("rst_mid_status", v, 32'h0040_0000);

    // Software IP bits are the only writable Cause bits
    issue(mtc0_op(8'h68, 32'hFFFF_FFFF));
    read_cp0(8'h68, v);
    check_eq("cause_sw_ip", v & 32'hBFFF_7FFF, 32'h0000_0300);
    read_cp0(8'h30, v);
    check_eq("cp0_unmapped", v, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
